// File: rtl/counter_pkg.sv
// Shared definitions for the counter family: width helper, mode constants and
// the elaboration-time parameter check reused by the counter benches.
package counter_pkg;

  localparam int CNT_WRAP = 0;
  localparam int CNT_SAT  = 1;

  function automatic int clog2(input int v);
    int r;
    int x;
    r = 0;
    x = v - 1;
    while (x > 0) begin
      r++;
      x = x >> 1;
    end
    return r;
  endfunction

endpackage

`ifndef COUNTER_CHECK_PARAMS
`define COUNTER_CHECK_PARAMS(sz, md, ps, st) \
  if ((md) < 2 || (md) > (2 ** (sz)) || (ps) < 1 || (ps) > 256 || \
      ((st) != CNT_WRAP && (st) != CNT_SAT)) begin : g_bad_params \
    $error("counter: illegal parameter combination"); \
  end
`endif

// File: rtl/counter_prescaler.sv
// Enable-gated prescaler: emits a step strobe on every Prescale-th enabled cycle.
module counter_prescaler
  import counter_pkg::*;
#(
  parameter int Prescale = 1
) (
  input  logic clock,
  input  logic reset,
  input  logic enable,
  input  logic restart,
  output logic step
);

  localparam int PW = (clog2(Prescale) > 1) ? clog2(Prescale) : 1;
  localparam logic [PW-1:0] LAST = PW'(Prescale - 1);

  logic [PW-1:0] phase;

  // restart (a load) suppresses the step so the load wins on a shared edge
  assign step = enable && !restart && (phase == LAST);

  always_ff @(posedge clock) begin
    if (reset || restart)
      phase <= '0;
    else if (enable)
      phase <= step ? '0 : phase + 1'b1;
  end

endmodule

// File: rtl/updown_mod_counter.sv
// Up/down modulo counter with parallel load, optional saturation, prescaled
// stepping, a boundary pulse and sticky overflow/underflow flags.
module updown_mod_counter
  import counter_pkg::*;
#(
  parameter int Size     = 5,
  parameter int Modulus  = 2 ** Size,
  parameter int Prescale = 1,
  parameter int Saturate = CNT_WRAP
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            enable,
  input  logic            up,
  input  logic            load,
  input  logic [Size-1:0] load_value,
  input  logic            clear_flag,
  output logic [Size-1:0] count,
  output logic            tick,
  output logic            wrap,
  output logic            overflow,
  output logic            underflow
);

  `COUNTER_CHECK_PARAMS(Size, Modulus, Prescale, Saturate)

  // One extra bit so Modulus == 2**Size compares without truncation
  localparam int W = Size + 1;
  localparam logic [W-1:0] MAXV = W'(Modulus - 1);
  localparam bit SAT = (Saturate == CNT_SAT);

  logic         step;
  logic [W-1:0] cnt_x, ld_x, ld_c, nxt_x;
  logic         bnd_up, bnd_dn;
  logic         unused_msb;

  counter_prescaler #(.Prescale(Prescale)) u_pre (
    .clock   (clock),
    .reset   (reset),
    .enable  (enable),
    .restart (load),
    .step    (step)
  );

  assign cnt_x = {1'b0, count};
  assign ld_x  = {1'b0, load_value};
  assign ld_c  = (ld_x > MAXV) ? MAXV : ld_x;

  always_comb begin
    nxt_x  = cnt_x;
    bnd_up = 1'b0;
    bnd_dn = 1'b0;
    if (up) begin
      if (cnt_x == MAXV) begin
        bnd_up = 1'b1;
        nxt_x  = SAT ? MAXV : '0;
      end else begin
        nxt_x = cnt_x + 1'b1;
      end
    end else begin
      if (cnt_x == '0) begin
        bnd_dn = 1'b1;
        nxt_x  = SAT ? '0 : MAXV;
      end else begin
        nxt_x = cnt_x - 1'b1;
      end
    end
  end

  // Result never exceeds MAXV, so the top bit is always zero
  assign unused_msb = nxt_x[Size] ^ ld_c[Size];

  always_ff @(posedge clock) begin
    if (reset) begin
      count     <= '0;
      tick      <= 1'b0;
      wrap      <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (load) begin
      count     <= ld_c[Size-1:0];
      tick      <= 1'b0;
      wrap      <= 1'b0;
      overflow  <= overflow & ~clear_flag;
      underflow <= underflow & ~clear_flag;
    end else begin
      if (step)
        count <= nxt_x[Size-1:0];
      tick      <= step;
      wrap      <= step & (bnd_up | bnd_dn);
      // a set on the same edge as clear_flag wins
      overflow  <= (step & bnd_up) | (overflow & ~clear_flag);
      underflow <= (step & bnd_dn) | (underflow & ~clear_flag);
    end
  end

endmodule
